// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
// Arbitrates the machine CSR file's single address/write port between
// pipeline CSR instructions and the hardware trap path. Traps, interrupts
// and mret stall the pipeline while a fixed write/read sequence runs
// (mepc, mcause, mtval writes, then an mtvec or mepc read), and the sequence
// ends with a one-cycle PC redirect.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   csr_req/_addr/_func/_data     pipeline CSR instruction; csr_grant when forwarded
//   trap_valid/_cause/_pc/_val    synchronous exception
//   irq, irq_en, irq_pc           level interrupt, global enable, PC to save
//   mret_valid                    mret in pipeline
//   csr_rdata                     CSR file read data (one cycle after address)
//   csr_sel/_addr/_func/_data     CSR file write enable, address, op, data
//   stall                         pipeline freeze
//   redirect_valid, redirect_pc   one-cycle PC redirect strobe and target
module csr_trap_ctrl #(
  parameter logic [4:0] MEPC_IDX   = 5'd1,
  parameter logic [4:0] MCAUSE_IDX = 5'd2,
  parameter logic [4:0] MTVAL_IDX  = 5'd3,
  parameter logic [4:0] MTVEC_IDX  = 5'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_req,
  input  logic [31:0] csr_req_addr,
  input  logic [2:0]  csr_req_func,
  input  logic [31:0] csr_req_data,
  output logic        csr_grant,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        irq,
  input  logic        irq_en,
  input  logic [31:0] irq_pc,
  input  logic        mret_valid,
  input  logic [31:0] csr_rdata,
  output logic        csr_sel,
  output logic [31:0] csr_addr,
  output logic [2:0]  csr_func,
  output logic [31:0] csr_data,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, RD_TVEC, RD_EPC, RD_WAIT, REDIRECT
  } state_t;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;
  localparam logic [2:0]  FUNC_WR   = 3'b001;

  state_t      state, state_nxt;
  logic [31:0] pc_q, cause_q, tval_q, target_q;
  logic        ret_q;   // 1: sequence came from mret, RD_WAIT captures mepc
  logic        take_trap, take_irq, take_mret;

  // Only the CSR file index bits of the pipeline address are meaningful.
  logic        req_addr_unused;
  assign req_addr_unused = ^csr_req_addr[31:5];

  // mtvec low bits hold the mode field; the target is the aligned base.
  function automatic logic [31:0] tvec_base(input logic [31:0] tvec);
    return {tvec[31:2], 2'b00};
  endfunction

  // Event decode: fixed priority, only in IDLE. Gated by rst so every
  // output reads zero while reset is held.
  always_comb begin
    take_trap = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    if (!rst && state == IDLE) begin
      if (trap_valid)          take_trap = 1'b1;
      else if (irq && irq_en)  take_irq  = 1'b1;
      else if (mret_valid)     take_mret = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    csr_sel        = 1'b0;
    csr_addr       = 32'h0;
    csr_func       = 3'b000;
    csr_data       = 32'h0;
    csr_grant      = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        if (take_trap || take_irq) begin
          stall     = 1'b1;
          state_nxt = W_EPC;
        end else if (take_mret) begin
          stall     = 1'b1;
          state_nxt = RD_EPC;
        end else if (csr_req && !rst) begin
          // Pipeline instruction passes straight through, no added latency.
          csr_grant = 1'b1;
          csr_sel   = 1'b1;
          csr_addr  = {27'b0, csr_req_addr[4:0]};
          csr_func  = csr_req_func;
          csr_data  = csr_req_data;
        end
      end
      W_EPC: begin
        stall     = 1'b1;
        csr_sel   = 1'b1;
        csr_addr  = {27'b0, MEPC_IDX};
        csr_func  = FUNC_WR;
        csr_data  = pc_q;
        state_nxt = W_CAUSE;
      end
      W_CAUSE: begin
        stall     = 1'b1;
        csr_sel   = 1'b1;
        csr_addr  = {27'b0, MCAUSE_IDX};
        csr_func  = FUNC_WR;
        csr_data  = cause_q;
        state_nxt = W_TVAL;
      end
      W_TVAL: begin
        stall     = 1'b1;
        csr_sel   = 1'b1;
        csr_addr  = {27'b0, MTVAL_IDX};
        csr_func  = FUNC_WR;
        csr_data  = tval_q;
        state_nxt = RD_TVEC;
      end
      RD_TVEC: begin
        stall     = 1'b1;
        csr_addr  = {27'b0, MTVEC_IDX};
        state_nxt = RD_WAIT;
      end
      RD_EPC: begin
        stall     = 1'b1;
        csr_addr  = {27'b0, MEPC_IDX};
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        // Hold the read address while the file returns its data.
        stall     = 1'b1;
        csr_addr  = ret_q ? {27'b0, MEPC_IDX} : {27'b0, MTVEC_IDX};
        state_nxt = REDIRECT;
      end
      REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event operands and redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= 32'h0;
      cause_q  <= 32'h0;
      tval_q   <= 32'h0;
      target_q <= 32'h0;
      ret_q    <= 1'b0;
    end else begin
      if (take_trap) begin
        pc_q    <= trap_pc;
        cause_q <= trap_cause;
        tval_q  <= trap_val;
        ret_q   <= 1'b0;
      end else if (take_irq) begin
        pc_q    <= irq_pc;
        cause_q <= IRQ_CAUSE;
        tval_q  <= 32'h0;
        ret_q   <= 1'b0;
      end else if (take_mret) begin
        ret_q   <= 1'b1;
      end
      if (state == RD_WAIT)
        target_q <= ret_q ? csr_rdata : tvec_base(csr_rdata);
    end
  end

  assign redirect_pc = target_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_req = 1'b0;
  logic [31:0] csr_req_addr = 32'h0;
  logic [2:0]  csr_req_func = 3'b0;
  logic [31:0] csr_req_data = 32'h0;
  logic        csr_grant;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_val = 32'h0;
  logic        irq = 1'b0;
  logic        irq_en = 1'b0;
  logic [31:0] irq_pc = 32'h0;
  logic        mret_valid = 1'b0;
  logic [31:0] csr_rdata = 32'h0;
  logic        csr_sel;
  logic [31:0] csr_addr;
  logic [2:0]  csr_func;
  logic [31:0] csr_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  // Expected CSR writes {idx, data, func} and expected redirect targets.
  logic [39:0] wq[$];
  logic [31:0] rq[$];

  logic [31:0] mem [32] = '{default: 32'h0};

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .csr_req(csr_req), .csr_req_addr(csr_req_addr), .csr_req_func(csr_req_func),
    .csr_req_data(csr_req_data), .csr_grant(csr_grant),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .irq(irq), .irq_en(irq_en), .irq_pc(irq_pc), .mret_valid(mret_valid),
    .csr_rdata(csr_rdata), .csr_sel(csr_sel), .csr_addr(csr_addr), .csr_func(csr_func),
    .csr_data(csr_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // CSR file model: write on csr_sel, registered read.
  always @(posedge clk) begin
    if (csr_sel === 1'b1) begin
      case (csr_func)
        3'b010:  mem[csr_addr[4:0]] <= mem[csr_addr[4:0]] | csr_data;
        3'b011:  mem[csr_addr[4:0]] <= mem[csr_addr[4:0]] & ~csr_data;
        default: mem[csr_addr[4:0]] <= csr_data;
      endcase
    end
    csr_rdata <= mem[csr_addr[4:0]];
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    logic [39:0] w;
    logic [31:0] r;
    if (csr_sel === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h func=%b", csr_addr, csr_data, csr_func);
      end else begin
        w = wq.pop_front();
        if (csr_addr !== {27'b0, w[39:35]} || csr_data !== w[34:3] || csr_func !== w[2:0]) begin
          errors++;
          $display("FAIL csr_write got addr=%h data=%h func=%b want addr=%h data=%h func=%b",
                   csr_addr, csr_data, csr_func, w[39:35], w[34:3], w[2:0]);
        end
      end
    end
    if (redirect_valid === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect pc=%h", redirect_pc);
      end else begin
        r = rq.pop_front();
        if (redirect_pc !== r) begin
          errors++;
          $display("FAIL redirect_pc got %h want %h", redirect_pc, r);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (csr_sel !== 1'b0) begin errors++; $display("FAIL rst_csr_sel got %b want 0", csr_sel); end
    checks++; if (csr_grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", csr_grant); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid got %b want 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc); end
    checks++; if (csr_addr !== 32'h0) begin errors++; $display("FAIL rst_csr_addr got %h want 0", csr_addr); end
    checks++; if (csr_func !== 3'h0) begin errors++; $display("FAIL rst_csr_func got %b want 0", csr_func); end
    checks++; if (csr_data !== 32'h0) begin errors++; $display("FAIL rst_csr_data got %h want 0", csr_data); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_csr_req();
    // Set-bits request, then a plain write that preloads mtvec.
    wq.push_back({5'd5, 32'h0000_000F, 3'b010});
    csr_req = 1'b1; csr_req_addr = 32'hFFFF_FFE5; csr_req_func = 3'b010; csr_req_data = 32'h0F;
    @(negedge clk);
    checks++; if (csr_grant !== 1'b1) begin errors++; $display("FAIL req_grant got %b want 1", csr_grant); end
    checks++; if (csr_sel !== 1'b1) begin errors++; $display("FAIL req_sel got %b want 1", csr_sel); end
    checks++; if (csr_addr !== 32'h5) begin errors++; $display("FAIL req_addr got %h want 5", csr_addr); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL req_stall got %b want 0", stall); end
    next_cycle();
    wq.push_back({5'd5, 32'h0000_0103, 3'b001});
    csr_req_addr = 32'h5; csr_req_func = 3'b001; csr_req_data = 32'h0000_0103;
    @(negedge clk);
    checks++; if (csr_grant !== 1'b1) begin errors++; $display("FAIL req2_grant got %b want 1", csr_grant); end
    next_cycle();
    csr_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_trap();
    wq.push_back({5'd1, 32'h0000_0040, 3'b001});
    wq.push_back({5'd2, 32'h0000_0002, 3'b001});
    wq.push_back({5'd3, 32'hDEAD_BEEF, 3'b001});
    rq.push_back(32'h0000_0100);
    trap_valid = 1'b1; trap_cause = 32'h2; trap_pc = 32'h40; trap_val = 32'hDEAD_BEEF;
    csr_req = 1'b1; csr_req_addr = 32'h5; csr_req_func = 3'b010; csr_req_data = 32'h0F;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (csr_grant !== 1'b0) begin errors++; $display("FAIL trap_drop_grant got %b want 0", csr_grant); end
      end
      checks++; if (stall !== (c <= 6)) begin errors++; $display("FAIL trap_stall c%0d got %b want %b", c, stall, (c <= 6)); end
      checks++; if (redirect_valid !== (c == 6)) begin errors++; $display("FAIL trap_redirect_valid c%0d got %b", c, redirect_valid); end
      next_cycle();
      trap_valid = 1'b0; csr_req = 1'b0;
    end
    checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL trap_pc_hold got %h want 100", redirect_pc); end
    checks++; if (wq.size() != 0 || rq.size() != 0) begin errors++; $display("FAIL trap_pending got %0d/%0d want 0/0", wq.size(), rq.size()); end
  endtask

  task automatic test_mret();
    wq.push_back({5'd1, 32'h0000_0044, 3'b001});
    csr_req = 1'b1; csr_req_addr = 32'h1; csr_req_func = 3'b001; csr_req_data = 32'h44;
    next_cycle();
    csr_req = 1'b0;
    rq.push_back(32'h0000_0044);
    mret_valid = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (stall !== (c <= 3)) begin errors++; $display("FAIL mret_stall c%0d got %b want %b", c, stall, (c <= 3)); end
      checks++; if (redirect_valid !== (c == 3)) begin errors++; $display("FAIL mret_redirect_valid c%0d got %b", c, redirect_valid); end
      if (c == 1) begin
        checks++;
        if (csr_addr !== 32'h1 || csr_sel !== 1'b0) begin
          errors++; $display("FAIL mret_rd_epc got addr=%h sel=%b want addr=1 sel=0", csr_addr, csr_sel);
        end
      end
      next_cycle();
      mret_valid = 1'b0;
    end
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL mret_pending got %0d want 0", rq.size()); end
  endtask

  task automatic test_irq();
    irq = 1'b1; irq_en = 1'b0; irq_pc = 32'h80;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL irq_masked_stall c%0d got %b want 0", c, stall); end
      next_cycle();
    end
    wq.push_back({5'd1, 32'h0000_0080, 3'b001});
    wq.push_back({5'd2, 32'h8000_000B, 3'b001});
    wq.push_back({5'd3, 32'h0000_0000, 3'b001});
    rq.push_back(32'h0000_0100);
    irq_en = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      checks++; if (stall !== (c <= 6)) begin errors++; $display("FAIL irq_stall c%0d got %b want %b", c, stall, (c <= 6)); end
      checks++; if (redirect_valid !== (c == 6)) begin errors++; $display("FAIL irq_redirect_valid c%0d got %b", c, redirect_valid); end
      next_cycle();
      irq = 1'b0;
    end
    irq_en = 1'b0;
    checks++; if (wq.size() != 0 || rq.size() != 0) begin errors++; $display("FAIL irq_pending got %0d/%0d want 0/0", wq.size(), rq.size()); end
  endtask

  task automatic test_back_to_back();
    // Trap beats simultaneous mret and csr_req; mret pulsed in W_CAUSE is
    // ignored; mret held at the first IDLE cycle starts a new sequence.
    wq.push_back({5'd1, 32'h0000_0200, 3'b001});
    wq.push_back({5'd2, 32'h0000_0007, 3'b001});
    wq.push_back({5'd3, 32'h0000_0011, 3'b001});
    rq.push_back(32'h0000_0100);
    rq.push_back(32'h0000_0200);
    trap_valid = 1'b1; trap_cause = 32'h7; trap_pc = 32'h200; trap_val = 32'h11;
    mret_valid = 1'b1;
    csr_req = 1'b1; csr_req_addr = 32'h4; csr_req_func = 3'b001; csr_req_data = 32'h55;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if (csr_grant !== 1'b0) begin errors++; $display("FAIL prio_grant got %b want 0", csr_grant); end
      end
      checks++; if (stall !== (c <= 10)) begin errors++; $display("FAIL b2b_stall c%0d got %b want %b", c, stall, (c <= 10)); end
      checks++; if (redirect_valid !== (c == 6 || c == 10)) begin errors++; $display("FAIL b2b_redirect_valid c%0d got %b", c, redirect_valid); end
      next_cycle();
      trap_valid = 1'b0; csr_req = 1'b0;
      mret_valid = (c + 1 == 2) || (c + 1 == 7);
    end
    checks++; if (wq.size() != 0 || rq.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d/%0d want 0/0", wq.size(), rq.size()); end
  endtask

  task automatic test_reset_mid();
    wq.push_back({5'd1, 32'h0000_0300, 3'b001});
    trap_valid = 1'b1; trap_cause = 32'h4; trap_pc = 32'h300; trap_val = 32'h5;
    @(negedge clk);
    next_cycle();
    trap_valid = 1'b0;
    @(negedge clk);
    next_cycle();
    // Now in W_CAUSE.
    rst = 1'b1;
    #1;
    checks++; if (csr_sel !== 1'b0) begin errors++; $display("FAIL midrst_sel got %b want 0", csr_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b want 0", stall); end
    checks++; if (csr_addr !== 32'h0 || csr_data !== 32'h0 || csr_func !== 3'h0) begin
      errors++; $display("FAIL midrst_bus got addr=%h data=%h func=%b want 0", csr_addr, csr_data, csr_func);
    end
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++; $display("FAIL midrst_redirect got %b/%h want 0/0", redirect_valid, redirect_pc);
    end
    checks++; if (csr_grant !== 1'b0) begin errors++; $display("FAIL midrst_grant got %b want 0", csr_grant); end
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL midrst_pending got %0d want 0", wq.size()); end
    wq.push_back({5'd1, 32'h0000_0400, 3'b001});
    wq.push_back({5'd2, 32'h0000_0005, 3'b001});
    wq.push_back({5'd3, 32'h0000_0006, 3'b001});
    rq.push_back(32'h0000_0100);
    trap_valid = 1'b1; trap_cause = 32'h5; trap_pc = 32'h400; trap_val = 32'h6;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      checks++; if (stall !== (c <= 6)) begin errors++; $display("FAIL postrst_stall c%0d got %b want %b", c, stall, (c <= 6)); end
      checks++; if (redirect_valid !== (c == 6)) begin errors++; $display("FAIL postrst_redirect_valid c%0d got %b", c, redirect_valid); end
      next_cycle();
      trap_valid = 1'b0;
    end
    checks++; if (wq.size() != 0 || rq.size() != 0) begin errors++; $display("FAIL postrst_pending got %0d/%0d want 0/0", wq.size(), rq.size()); end
  endtask

  initial begin
    test_reset();
    test_csr_req();
    test_trap();
    test_mret();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Sequencer and arbiter for the 32-entry machine CSR register file. Shares the file's single address/write port between the pipeline's CSR instructions and the hardware trap path. On an exception, interrupt or `mret`, it stalls the pipeline and performs the required multi-cycle write/read sequence (mepc, mcause, mtval, mtvec). It sits between the EX/MEM stage and the CSR file, and drives the PC redirect.

## Interface
- `MEPC_IDX`, default 5'd1, CSR file index of mepc
- `MCAUSE_IDX`, default 5'd2, index of mcause
- `MTVAL_IDX`, default 5'd3, index of mtval
- `MTVEC_IDX`, default 5'd5, index of mtvec
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `csr_req`  in  1  pipeline CSR instruction present
- `csr_req_addr`  in  32  pipeline CSR address (low 5 bits used)
- `csr_req_func`  in  3  pipeline funct3
- `csr_req_data`  in  32  pipeline rs1/zimm operand
- `csr_grant`  out  1  pipeline request forwarded this cycle
- `trap_valid`  in  1  synchronous exception
- `trap_cause`  in  32  exception cause
- `trap_pc`  in  32  faulting PC
- `trap_val`  in  32  mtval value
- `irq`  in  1  external interrupt, level
- `irq_en`  in  1  global interrupt enable
- `irq_pc`  in  32  PC to save on interrupt
- `mret_valid`  in  1  mret in pipeline
- `csr_rdata`  in  32  CSR file read data; valid the cycle after the address is driven
- `csr_sel`  out  1  CSR file write enable
- `csr_addr`  out  32  CSR file address, upper 27 bits zero
- `csr_func`  out  3  CSR file op
- `csr_data`  out  32  CSR file write data
- `stall`  out  1  freeze pipeline
- `redirect_valid`  out  1  one-cycle PC redirect strobe
- `redirect_pc`  out  32  redirect target

## Operation
- States: IDLE, W_EPC, W_CAUSE, W_TVAL, RD_TVEC, RD_EPC, RD_WAIT, REDIRECT.
- Priority in IDLE: trap_valid > (irq & irq_en) > mret_valid > csr_req.
- Trap accept: latch trap_pc, trap_cause and trap_val, then go to W_EPC.
- Interrupt accept: latch irq_pc, cause 32'h8000000B and tval 0, then go to W_EPC.
- mret accept: go to RD_EPC.
- IDLE with csr_req and no higher-priority event:
  - Drive csr_sel=1, csr_addr={27'b0,csr_req_addr[4:0]}, csr_func=csr_req_func, csr_data=csr_req_data.
  - Assert csr_grant=1 (combinational). No state change.
- csr_req in the same cycle as an accepted event: dropped. csr_grant=0 and no write occurs; the event cancels the instruction.
- Write states each drive csr_sel=1 and csr_func=3'b001 (plain write):
  - W_EPC writes the latched pc to MEPC_IDX.
  - W_CAUSE writes the latched cause to MCAUSE_IDX.
  - W_TVAL writes the latched tval to MTVAL_IDX.
- Read states drive csr_sel=0:
  - RD_TVEC drives MTVEC_IDX.
  - RD_EPC drives MEPC_IDX.
- RD_WAIT holds the same address. Capture csr_rdata into the target register: mtvec value with bits[1:0] forced to 0, or the mepc value unmodified.
- REDIRECT: redirect_valid=1, redirect_pc=captured target, then go to IDLE.
- Outside the cases above: csr_sel=0, csr_func=0, csr_data=0, csr_addr=0.
- Events arriving while not in IDLE are ignored. Requesters must hold them (pipeline is stalled).

## Timing
- Reset (async, any state): state=IDLE; latched pc/cause/tval/target=0.
- Reset values of all outputs: csr_sel=0, csr_grant=0, stall=0, redirect_valid=0, redirect_pc=0, csr_addr=0, csr_func=0, csr_data=0.
- stall is combinational. It is 1 in the accept cycle of any trap, interrupt or mret event, and in every non-IDLE state including REDIRECT. It is 0 in IDLE otherwise.
- Trap/irq latency: accept at cycle 0; W_EPC 1, W_CAUSE 2, W_TVAL 3, RD_TVEC 4, RD_WAIT 5, REDIRECT 6. Back in IDLE at cycle 7.
- mret latency: accept 0; RD_EPC 1, RD_WAIT 2, REDIRECT 3. Back in IDLE at cycle 4.
- redirect_valid is high for exactly one cycle. redirect_pc holds its last value afterwards.
- Pipeline CSR write: zero added latency and no stall.
- Back-to-back: a new event may be accepted in the first IDLE cycle after REDIRECT.
- Reset mid-sequence aborts it. Partial CSR writes already done remain (the CSR file has its own reset).

## Test plan
- Trap, cause 2, pc 32'h0000_0040, tval 32'hDEAD_BEEF, mtvec preloaded 32'h0000_0103 -> writes in cycles 1–3 at indices 1/2/3 with those values; redirect_pc=32'h0000_0100 at cycle 6; stall high cycles 0–6.
- mret with mepc=32'h0000_0044 -> RD_EPC at addr 1; redirect_valid at cycle 3 with 32'h0000_0044; stall cycles 0–3.
- irq=1, irq_en=1, irq_pc=32'h80 -> mcause write 32'h8000000B, mtval write 0; with irq_en=0 no sequence starts and stall=0.
- csr_req (addr 5, func 3'b010, data 32'h0F) in IDLE -> csr_grant=1, csr_sel=1, addr 5 passed through the same cycle, stall=0. Same request together with trap_valid -> csr_grant=0 and the trap sequence starts.
- trap_valid, mret_valid and csr_req all asserted together -> trap wins, csr_grant=0.
- mret asserted during W_CAUSE -> ignored.
- rst pulsed during W_CAUSE -> all outputs 0 immediately, state IDLE. The next trap runs the full 7-cycle sequence.
